// File: rtl/mac_unit.sv
// -----------------------------------------------------------------------------
// mac_unit
//   Signed fixed-point multiply-accumulate element: acc_out = acc_in + a*b.
//   The caller owns the running accumulator and feeds it back on acc_in.
//
//   Parameters
//     DATA_WIDTH : operand width (two's complement)
//     ACC_WIDTH  : accumulator width, must be >= 2*DATA_WIDTH
//     PIPELINED  : 0 -> single register stage (latency 1)
//                  1 -> product/acc_in register + accumulate register (latency 2)
//
//   Ports
//     clk        : rising-edge clock
//     rst        : asynchronous reset, active-high
//     en         : issue enable (an op issues when en && valid_in)
//     valid_in   : operand valid qualifier
//     a, b       : signed operands
//     acc_in     : signed partial sum
//     acc_out    : signed registered result, holds between results
//     valid_out  : one-cycle pulse when acc_out presents a new result
//
//   Build option
//     MAC_SATURATE_EN : when defined, the add clamps to the signed ACC_WIDTH
//                       range instead of wrapping. Latency is unchanged.
// -----------------------------------------------------------------------------
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 40,
    parameter int PIPELINED  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         valid_in,
    input  logic signed [DATA_WIDTH-1:0] a,
    input  logic signed [DATA_WIDTH-1:0] b,
    input  logic signed [ACC_WIDTH-1:0]  acc_in,
    output logic signed [ACC_WIDTH-1:0]  acc_out,
    output logic                         valid_out
);

    localparam int PROD_WIDTH = 2 * DATA_WIDTH;

    generate
        if (ACC_WIDTH < PROD_WIDTH) begin : g_width_check
            $error("mac_unit: ACC_WIDTH must be >= 2*DATA_WIDTH");
        end
    endgenerate

    logic                        issue;
    logic signed [PROD_WIDTH-1:0] product;
    logic signed [ACC_WIDTH-1:0]  product_ext;

    // Operands seen by the final adder and the qualifier that loads acc_out.
    logic signed [ACC_WIDTH-1:0]  add_prod;
    logic signed [ACC_WIDTH-1:0]  add_acc;
    logic                         add_fire;
    logic signed [ACC_WIDTH-1:0]  sum;

    assign issue       = en & valid_in;
    assign product     = a * b;
    // Signed size cast sign-extends the full-precision product.
    assign product_ext = ACC_WIDTH'(product);

    generate
        if (PIPELINED != 0) begin : g_pipe
            logic signed [ACC_WIDTH-1:0] prod_q;
            logic signed [ACC_WIDTH-1:0] acc_q;
            logic                        valid_q;

            // Input stage only captures on issue; the valid flag itself is
            // refreshed every cycle so stage 2 drains even if en drops.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    prod_q  <= '0;
                    acc_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= issue;
                    if (issue) begin
                        prod_q <= product_ext;
                        acc_q  <= acc_in;
                    end
                end
            end

            assign add_prod = prod_q;
            assign add_acc  = acc_q;
            assign add_fire = valid_q;
        end else begin : g_nopipe
            assign add_prod = product_ext;
            assign add_acc  = acc_in;
            assign add_fire = issue;
        end
    endgenerate

`ifdef MAC_SATURATE_EN
    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH:0] sum_wide;

    assign sum_wide = {add_acc[ACC_WIDTH-1], add_acc} + {add_prod[ACC_WIDTH-1], add_prod};

    // The two top bits of the extended sum disagree only on overflow; the
    // extra bit then carries the true sign and picks the clamp direction.
    always_comb begin
        sum = sum_wide[ACC_WIDTH-1:0];
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end
    end
`else
    assign sum = add_acc + add_prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= add_fire;
            if (add_fire) begin
                acc_out <= sum;
            end
        end
    end

endmodule

// File: tb/tb_mac_unit.sv
module tb_mac_unit;

    localparam int DW = 16;
    localparam int AW = 40;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  en = 1'b0;
    logic                  valid_in = 1'b0;
    logic signed [DW-1:0]  a = '0;
    logic signed [DW-1:0]  b = '0;
    logic signed [AW-1:0]  acc_in = '0;
    logic signed [AW-1:0]  acc0, acc1;
    logic                  v0, v1;

    int tests_run = 0;
    int tests_failed = 0;
    int cyc = 0;

    typedef struct {
        logic signed [AW-1:0] exp;
        int                   due;
    } sb_t;

    sb_t q0[$];
    sb_t q1[$];
    logic signed [AW-1:0] last0, last1;

    mac_unit #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPELINED(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .a(a), .b(b),
        .acc_in(acc_in), .acc_out(acc0), .valid_out(v0)
    );

    mac_unit #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .PIPELINED(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .valid_in(valid_in), .a(a), .b(b),
        .acc_in(acc_in), .acc_out(acc1), .valid_out(v1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic signed [AW-1:0] model(input logic signed [DW-1:0] ma,
                                                   input logic signed [DW-1:0] mb,
                                                   input logic signed [AW-1:0] macc);
        longint p, s;
        logic signed [63:0] sv;
        p  = longint'(ma) * longint'(mb);
        s  = longint'(macc) + p;
`ifdef MAC_SATURATE_EN
        if (s > ((64'sd1 <<< (AW-1)) - 1)) s = (64'sd1 <<< (AW-1)) - 1;
        if (s < -(64'sd1 <<< (AW-1)))      s = -(64'sd1 <<< (AW-1));
`endif
        sv = s;
        return sv[AW-1:0];
    endfunction

    // Scoreboard monitors: every result must match the oldest expected entry
    // and arrive in the predicted cycle; between results acc_out must hold.
    always @(negedge clk) begin
        if (rst) begin
            last0 = acc0;
        end else if (v0) begin
            tests_run++;
            if (q0.size() == 0) begin
                tests_failed++;
                $display("FAIL sb0_unexpected: got valid acc=%0d, required no result", acc0);
            end else begin
                sb_t it;
                it = q0.pop_front();
                if (acc0 !== it.exp || cyc !== it.due) begin
                    tests_failed++;
                    $display("FAIL sb0_result: got acc=%0d cyc=%0d, required acc=%0d cyc=%0d",
                             acc0, cyc, it.exp, it.due);
                end
            end
            last0 = acc0;
        end else begin
            tests_run++;
            if (acc0 !== last0) begin
                tests_failed++;
                $display("FAIL sb0_hold: got acc=%0d, required %0d", acc0, last0);
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            last1 = acc1;
        end else if (v1) begin
            tests_run++;
            if (q1.size() == 0) begin
                tests_failed++;
                $display("FAIL sb1_unexpected: got valid acc=%0d, required no result", acc1);
            end else begin
                sb_t it;
                it = q1.pop_front();
                if (acc1 !== it.exp || cyc !== it.due) begin
                    tests_failed++;
                    $display("FAIL sb1_result: got acc=%0d cyc=%0d, required acc=%0d cyc=%0d",
                             acc1, cyc, it.exp, it.due);
                end
            end
            last1 = acc1;
        end else begin
            tests_run++;
            if (acc1 !== last1) begin
                tests_failed++;
                $display("FAIL sb1_hold: got acc=%0d, required %0d", acc1, last1);
            end
        end
    end

    task automatic drive(input logic e, input logic v,
                         input logic signed [DW-1:0] ta,
                         input logic signed [DW-1:0] tb_,
                         input logic signed [AW-1:0] tacc);
        sb_t it;
        @(negedge clk);
        en = e; valid_in = v; a = ta; b = tb_; acc_in = tacc;
        if (e && v) begin
            it.exp = model(ta, tb_, tacc);
            it.due = cyc + 1;
            q0.push_back(it);
            it.due = cyc + 2;
            q1.push_back(it);
        end
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, '0, '0, '0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (acc0 !== '0 || v0 !== 1'b0 || acc1 !== '0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_state: got acc0=%0d v0=%b acc1=%0d v1=%b, required 0/0/0/0",
                     acc0, v0, acc1, v1);
        end
        rst = 1'b0;
        repeat (3) begin
            idle();
            tests_run++;
            if (acc0 !== '0 || v0 !== 1'b0 || acc1 !== '0 || v1 !== 1'b0) begin
                tests_failed++;
                $display("FAIL reset_release: got acc0=%0d v0=%b acc1=%0d v1=%b, required 0/0/0/0",
                         acc0, v0, acc1, v1);
            end
        end
    endtask

    task automatic test_chain();
        logic signed [DW-1:0] va[4] = '{16384, -8192, 3277, 16384};
        logic signed [DW-1:0] vb[4] = '{8192, 16384, -3277, -16384};
        logic signed [AW-1:0] vc[4] = '{0, 134217728, 0, -10738729};
        logic signed [AW-1:0] vr[4] = '{134217728, 0, -10738729, -279174185};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b1, va[i], vb[i], vc[i]);
            idle();
            tests_run++;
            if (acc0 !== vr[i]) begin
                tests_failed++;
                $display("FAIL chain0_%0d: got %0d, required %0d", i, acc0, vr[i]);
            end
            idle();
            tests_run++;
            if (acc1 !== vr[i]) begin
                tests_failed++;
                $display("FAIL chain1_%0d: got %0d, required %0d", i, acc1, vr[i]);
            end
        end
    endtask

    task automatic test_latency();
        drive(1'b1, 1'b1, 16'sd5, 16'sd7, 40'sd100);
        idle();
        tests_run++;
        if (v0 !== 1'b1 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_c1: got v0=%b v1=%b, required 1 0", v0, v1);
        end
        idle();
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL latency_c2: got v0=%b v1=%b, required 0 1", v0, v1);
        end
        idle();
        tests_run++;
        if (v0 !== 1'b0 || v1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL latency_c3: got v0=%b v1=%b, required 0 0", v0, v1);
        end
    endtask

    task automatic test_gating();
        logic signed [AW-1:0] h0, h1;
        h0 = acc0;
        h1 = acc1;
        for (int i = 0; i < 8; i++) begin
            if (i < 3)      drive(1'b0, 1'b1, 16'sd100, 16'sd100, 40'sd0);
            else if (i < 6) drive(1'b1, 1'b0, 16'sd100, 16'sd100, 40'sd0);
            else            idle();
            tests_run++;
            if (v0 !== 1'b0 || v1 !== 1'b0 || acc0 !== h0 || acc1 !== h1) begin
                tests_failed++;
                $display("FAIL gating_%0d: got v0=%b v1=%b acc0=%0d acc1=%0d, required 0 0 %0d %0d",
                         i, v0, v1, acc0, acc1, h0, h1);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] m0, m1;
        m0 = '0;
        m1 = '0;
        for (int i = 0; i < 6; i++) begin
            case (i)
                0: drive(1'b1, 1'b1, 16'sd1000, 16'sd2000, 40'sd5);
                1: drive(1'b1, 1'b1, -16'sd300, 16'sd400, -40'sd7);
                2: drive(1'b1, 1'b1, 16'sd32767, 16'sd32767, 40'sd1);
                default: idle();
            endcase
            m0[i] = v0;
            m1[i] = v1;
        end
        tests_run++;
        if (m0 !== 6'b001110 || m1 !== 6'b011100) begin
            tests_failed++;
            $display("FAIL back_to_back: got v0 mask=%b v1 mask=%b, required 001110 011100", m0, m1);
        end
    endtask

    task automatic test_corner_overflow();
        logic signed [AW-1:0] exp_pos, exp_neg;
`ifdef MAC_SATURATE_EN
        exp_pos = 40'sh7F_FFFF_FFFF;
        exp_neg = 40'sh80_0000_0000;
`else
        exp_pos = 40'sh80_0FFF_FFFF;
        exp_neg = 40'sh7F_C000_8000;
`endif
        drive(1'b1, 1'b1, -16'sd32768, -16'sd32768, 40'sd0);
        idle();
        tests_run++;
        if (acc0 !== 40'sd1073741824) begin
            tests_failed++;
            $display("FAIL corner_min_min: got %0d, required 1073741824", acc0);
        end
        idle();
        drive(1'b1, 1'b1, 16'sd16384, 16'sd16384, 40'sh7F_FFFF_FFFF);
        idle();
        tests_run++;
        if (acc0 !== exp_pos) begin
            tests_failed++;
            $display("FAIL overflow_pos0: got %0d, required %0d", acc0, exp_pos);
        end
        idle();
        tests_run++;
        if (acc1 !== exp_pos) begin
            tests_failed++;
            $display("FAIL overflow_pos1: got %0d, required %0d", acc1, exp_pos);
        end
        drive(1'b1, 1'b1, -16'sd32768, 16'sd32767, 40'sh80_0000_0000);
        idle();
        tests_run++;
        if (acc0 !== exp_neg) begin
            tests_failed++;
            $display("FAIL overflow_neg0: got %0d, required %0d", acc0, exp_neg);
        end
        idle();
    endtask

    task automatic test_random();
        logic [63:0] r;
        for (int i = 0; i < 40; i++) begin
            r = {$urandom(), $urandom()};
            drive(($urandom_range(3, 0) != 0), ($urandom_range(3, 0) != 0),
                  DW'($urandom()), DW'($urandom()), r[AW-1:0]);
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid_op();
        drive(1'b1, 1'b1, 16'sd123, 16'sd456, 40'sd789);
        @(posedge clk);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        en = 1'b0;
        valid_in = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idle();
            tests_run++;
            if (v0 !== 1'b0 || v1 !== 1'b0 || acc0 !== '0 || acc1 !== '0) begin
                tests_failed++;
                $display("FAIL reset_mid_%0d: got v0=%b v1=%b acc0=%0d acc1=%0d, required 0 0 0 0",
                         i, v0, v1, acc0, acc1);
            end
        end
    endtask

    task automatic test_drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 10) begin
            idle();
            n++;
        end
        tests_run++;
        if (q0.size() != 0 || q1.size() != 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d/%0d pending results, required 0/0", q0.size(), q1.size());
        end
    endtask

    initial begin
        test_reset();
        test_chain();
        test_latency();
        test_gating();
        test_back_to_back();
        test_corner_overflow();
        test_random();
        test_drain();
        test_reset_mid_op();
        test_drain();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule
